mux_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one N:1 bit multiplexer (the mux32x1 datapath) between N requesters. It arbitrates the request vector and drives the mux select with a one-hot grant and a bounded dwell time. It also registers the selected data bit, so each downstream consumer sees a clean, valid-qualified sample. It sits between the requesting lanes and the shared mux output path.

---
 rtl/mux_rr_scheduler.sv | 107 ++++++++++
 tb/tb_mux_rr_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one N:1 bit mux between N requesters.
// Grants are one-hot with a bounded dwell time. Each grant is followed by one
// idle turnaround cycle. The selected data bit is registered with a valid
// qualifier that trails the grant by one cycle.
module mux_rr_scheduler #(
   parameter int N        = 32,
   parameter int SEL_W    = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     din,
   output logic [SEL_W-1:0] sel,
   output logic [N-1:0]     gnt,
   output logic             gnt_valid,
   output logic             dout,
   output logic             dout_valid
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_sel;
   logic [3:0]       r_hold;
   logic [N-1:0]     r_gnt;
   logic             r_gnt_valid;
   logic             r_dout;
   logic             r_dout_valid;

   logic [2*N-1:0]   w_dbl;
   logic [N-1:0]     w_rot;
   logic             w_found;
   logic [SEL_W-1:0] w_pick;
   logic             w_release;
   logic [SEL_W-1:0] w_ptr_nxt;

   // Rotate the request vector so bit j is requester (ptr+j) mod N.
   assign w_dbl = {req, req};
   assign w_rot = N'(w_dbl >> r_ptr);

   // Pick the lowest rotated offset that is requesting; scanning downward
   // lets the smallest offset overwrite all others.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int j = N-1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_found = 1'b1;
            if (int'(r_ptr) + j >= N)
               w_pick = SEL_W'(int'(r_ptr) + j - N);
            else
               w_pick = SEL_W'(int'(r_ptr) + j);
         end
      end
   end

   // A grant ends when its requester lets go, the scheduler is disabled or
   // the dwell limit is reached.
   assign w_release = !req[r_sel] || !en || (r_hold == 4'(MAX_HOLD-1));
   assign w_ptr_nxt = (r_sel == SEL_W'(N-1)) ? '0 : r_sel + 1'b1;

   // Two-state arbiter FSM plus the registered mux sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_sel        <= '0;
         r_hold       <= '0;
         r_gnt        <= '0;
         r_gnt_valid  <= 1'b0;
         r_dout       <= 1'b0;
         r_dout_valid <= 1'b0;
      end else if (r_state == IDLE) begin
         r_dout_valid <= 1'b0;
         if (en && w_found) begin
            r_sel       <= w_pick;
            r_gnt       <= N'(1) << w_pick;
            r_gnt_valid <= 1'b1;
            r_hold      <= '0;
            r_state     <= GRANT;
         end
      end else begin
         r_dout       <= din[r_sel];
         r_dout_valid <= 1'b1;
         if (w_release) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_hold      <= '0;
            r_ptr       <= w_ptr_nxt;
         end else begin
            r_hold <= r_hold + 4'd1;
         end
      end
   end

   assign sel        = r_sel;
   assign gnt        = r_gnt;
   assign gnt_valid  = r_gnt_valid;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: a cycle model pushes expected outputs to a
// scoreboard queue as each stimulus cycle is driven; they are popped and
// compared after the edge. A grant log built from observed outputs is
// checked against fixed expected grant orders, lengths and gaps.
module tb_mux_rr_scheduler;
   localparam int N        = 32;
   localparam int SEL_W    = 5;
   localparam int MAX_HOLD = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             en = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N-1:0]     din = '0;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic             dout;
   logic             dout_valid;

   mux_rr_scheduler #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .din(din),
      .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid),
      .dout(dout), .dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SEL_W-1:0] sel;
      logic [N-1:0]     gnt;
      logic             gv;
      logic             dout;
      logic             dv;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   bit           m_state;
   int           m_ptr, m_hold, m_sel;
   logic [N-1:0] m_gnt;
   logic         m_gv, m_dout, m_dv;

   // observed grant log
   int lg_sel[$], lg_len[$], lg_gap[$];
   int cur_sel, cur_len, idle_run;
   logic prev_gv;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_ptr = 0; m_hold = 0; m_sel = 0;
      m_gnt = '0; m_gv = 0; m_dout = 0; m_dv = 0;
      q.delete();
      lg_sel.delete(); lg_len.delete(); lg_gap.delete();
      cur_sel = 0; cur_len = 0; idle_run = 0; prev_gv = 0;
   endtask

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_next();
      int k;
      exp_t e;
      if (m_state) begin
         m_dout = din[m_sel];
         m_dv   = 1;
         if (!req[m_sel] || !en || m_hold == MAX_HOLD-1) begin
            m_state = 0; m_gnt = '0; m_gv = 0; m_hold = 0;
            m_ptr = (m_sel + 1) % N;
         end else begin
            m_hold++;
         end
      end else begin
         m_dv = 0;
         if (en && req != '0) begin
            k = m_ptr;
            while (!req[k]) k = (k + 1) % N;
            m_sel = k; m_gnt = '0; m_gnt[k] = 1'b1;
            m_gv = 1; m_hold = 0; m_state = 1;
         end
      end
      e.sel = SEL_W'(m_sel); e.gnt = m_gnt; e.gv = m_gv;
      e.dout = m_dout; e.dv = m_dv;
      q.push_back(e);
   endtask

   task automatic step(input logic e, input logic [N-1:0] r, input logic [N-1:0] d);
      exp_t x;
      en = e; req = r; din = d;
      model_next();
      @(posedge clk);
      #1;
      x = q.pop_front();
      chk("sel", sel, x.sel);
      chk("gnt", gnt, x.gnt);
      chk("gnt_valid", gnt_valid, x.gv);
      chk("dout_valid", dout_valid, x.dv);
      chk("dout", dout, x.dout);
      if (gnt_valid && !prev_gv) begin
         lg_gap.push_back(idle_run);
         idle_run = 0; cur_sel = sel; cur_len = 1;
      end else if (gnt_valid) begin
         cur_len++;
      end else begin
         if (prev_gv) begin
            lg_sel.push_back(cur_sel);
            lg_len.push_back(cur_len);
         end
         idle_run++;
      end
      prev_gv = gnt_valid;
   endtask

   // Assert reset, check outputs before any clock edge, then release.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_sel"}, sel, 0);
      chk({tag, "_rst_gnt"}, gnt, 0);
      chk({tag, "_rst_gv"}, gnt_valid, 0);
      chk({tag, "_rst_dv"}, dout_valid, 0);
      chk({tag, "_rst_dout"}, dout, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic tog;
      // Reset with everyone requesting; first grant must go to 0.
      en = 1'b1; req = '1;
      #2;
      do_reset("init");
      step(1'b1, '1, $urandom);
      chk("first_sel", sel, 0);
      chk("first_gnt", gnt, 32'h1);
      chk("first_gv", gnt_valid, 1);

      // Single requester hits the dwell limit, one idle cycle, regranted.
      do_reset("hold");
      for (int i = 0; i < 20; i++) step(1'b1, 32'h4, $urandom);
      chk("hold_sel0", lg_sel[0], 2);
      chk("hold_len0", lg_len[0], MAX_HOLD);
      chk("hold_sel1", lg_sel[1], 2);
      chk("hold_len1", lg_len[1], MAX_HOLD);
      chk("hold_gap", lg_gap[1], 1);

      // Wrap-around between requesters 0 and 31.
      do_reset("wrap");
      for (int i = 0; i < 40; i++) step(1'b1, 32'h8000_0001, $urandom);
      chk("wrap_g0", lg_sel[0], 0);
      chk("wrap_g1", lg_sel[1], 31);
      chk("wrap_g2", lg_sel[2], 0);
      chk("wrap_g3", lg_sel[3], 31);
      chk("wrap_len3", lg_len[3], MAX_HOLD);
      chk("wrap_gap3", lg_gap[3], 1);

      // Early release in 3rd grant cycle; pointer moves to 6, wraps to 0.
      do_reset("early");
      for (int i = 0; i < 3; i++) step(1'b1, 32'h20, $urandom);
      step(1'b1, 32'h0, $urandom);
      for (int i = 0; i < 11; i++) step(1'b1, 32'h21, $urandom);
      chk("early_sel0", lg_sel[0], 5);
      chk("early_len0", lg_len[0], 3);
      chk("early_sel1", lg_sel[1], 0);

      // Datapath: din[7] toggles, other bits random.
      do_reset("data");
      tog = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic [N-1:0] d;
         d = $urandom;
         d[7] = tog;
         tog = ~tog;
         step(1'b1, 32'h80, d);
      end
      chk("data_sel", lg_sel[0], 7);
      chk("data_len", lg_len[0], MAX_HOLD);

      // Disable in 2nd grant cycle; nothing granted while disabled.
      do_reset("en");
      for (int i = 0; i < 2; i++) step(1'b1, 32'h10, $urandom);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h10, $urandom);
      for (int i = 0; i < 2; i++) step(1'b1, 32'h10, $urandom);
      chk("en_sel", lg_sel[0], 4);
      chk("en_len", lg_len[0], 2);
      chk("en_gap", lg_gap[1], 4);

      // Asynchronous reset mid-grant with dout driven high.
      do_reset("mid");
      for (int i = 0; i < 3; i++) step(1'b1, 32'h40, '1);
      chk("mid_pre_gv", gnt_valid, 1);
      chk("mid_pre_dout", dout, 1);
      #2;
      do_reset("mid");
      step(1'b1, 32'h40, $urandom);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
